// File: rtl/uart_tx_serializer_pkg.sv
// Shared constants and state encoding for the UART transmit serializer.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  // Baud ticks per bit cell (16x oversampling clock).
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Request/status bundle between the test-sequencing FSM (master) and the
// UART transmit serializer (slave).
//   tx_start : one-cycle send request
//   din      : byte to send, sampled on the accept cycle
//   tx       : serial line, idle high
//   busy     : frame in progress
//   tx_done  : one-cycle pulse at end of stop bit
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] din;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (output tx_start, din, input tx, busy, tx_done);
  modport slave  (input tx_start, din, output tx, busy, tx_done);
endinterface

// File: rtl/uart_tx_serializer_baud_tick.sv
// 16x oversampling baud tick generator.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous restart of the divider (frame accept)
//   tick : one-clk pulse every DIV clocks, high while count == DIV-1
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: accepts a one-cycle tx_start, serializes din LSB-first
// as 8N1 (start, DATA_BITS data, STOP_TICKS/16 stop bits) and pulses tx_done
// when the stop bit completes.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit cell between
// data and stop; PARITY_ODD=1 selects odd parity.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset (aborts a frame, no tx_done)
//   bus : uart_tx_serializer_if.slave (tx_start, din in; tx, busy, tx_done out)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_serializer_if.slave   bus
);
  localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TMAX = (STOP_TICKS > OVERSAMPLE) ? STOP_TICKS : OVERSAMPLE;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  if (DIV < 1) begin : g_div_chk
    $error("uart_tx_serializer: CLK_FREQ/(BAUD*16) must be >= 1");
  end

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic [TW-1:0]        tck_q, tck_n;
  logic                 tx_q, tx_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 tick, clr;
  logic                 last_cell, last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Final tick of a 16-tick bit cell, and of the (possibly longer) stop cell.
  assign last_cell = tick && (tck_q == TW'(OVERSAMPLE - 1));
  assign last_stop = tick && (tck_q == TW'(STOP_TICKS - 1));

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    bit_n   = bit_q;
    tck_n   = tck_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    clr     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    // Tick counter advances in every active state; cell ends reset it below.
    if (state != IDLE && tick) tck_n = tck_q + 1'b1;

    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        tck_n  = '0;
        if (bus.tx_start) begin
          shift_n = bus.din;
          bit_n   = '0;
          state_n = START;
          busy_n  = 1'b1;
          tx_n    = 1'b0;
          clr     = 1'b1;  // restart divider so every frame has fixed timing
`ifdef UART_TX_PARITY_EN
          par_n   = (^bus.din) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        if (last_cell) begin
          tck_n   = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (last_cell) begin
          tck_n   = '0;
          shift_n = shift_q >> 1;
          tx_n    = shift_n[0];
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last_cell) begin
          tck_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (last_stop) begin
          tck_n   = '0;
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tck_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      bit_q   <= bit_n;
      tck_q   <= tck_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit stage that consumes the one-cycle tx_start pulse from the test-sequencing FSM and serializes one data byte onto the tx line. Frame format is LSB-first 8N1 by default. Returns a one-cycle tx_done pulse when the stop bit completes, which the FSM waits on before advancing channels. Contains its own 16x oversampling baud-tick generator.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/(BAUD*16) truncated, must be >= 1
DATA_BITS, 8, payload bits per frame
STOP_TICKS, 16, stop-bit length in baud ticks (16 = 1 stop, 32 = 2 stop)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_start  in  1  single-cycle request; accepted only when busy=0
din  in  DATA_BITS  byte to send; sampled on the accept cycle only
tx  out  1  serial line, idle high
busy  out  1  high from the cycle after accept until tx_done
tx_done  out  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset (async): state=IDLE, tx=1, busy=0, tx_done=0, shift reg, bit count, tick count and divider all 0. Reset mid-frame aborts immediately; tx goes to 1 and no tx_done is issued.
- Tick generator: counts 0..DIV-1; tick=1 for one clk when count==DIV-1. Cleared on accept so frame timing is deterministic. Each bit lasts exactly 16 ticks = 16*DIV clocks.
- States: IDLE, START, DATA, STOP (plus PARITY when enabled).
- IDLE: tx=1. If tx_start=1, latch din into the shift register. Next cycle: state=START, busy=1, tx=0.
- START: tx=0. After 16 ticks go to DATA with bit count 0.
- DATA: tx=shift[0]. After 16 ticks, shift right; bit count+1. When bit count==DATA_BITS-1 at the 16th tick, go to STOP (or PARITY).
- STOP: tx=1. After STOP_TICKS ticks, go to IDLE, pulse tx_done for exactly that next cycle, and drop busy in the same cycle.
- Latency: accept to tx falling edge is 1 clk. Total frame is (16*(1+DATA_BITS)+STOP_TICKS)*DIV clocks.
- tx_start while busy=1 is ignored; no queuing and no error flag. din changes after accept have no effect.
- Back-to-back: tx_start asserted in the tx_done cycle (state IDLE) is accepted; the new start bit begins the following cycle.
- tx is driven from a register, so there are no glitches.

Optional Feature:
- Macro UART_TX_PARITY_EN. When defined, a PARITY state is inserted between DATA and STOP and lasts 16 ticks. tx = even parity (XOR of all data bits); compile-time parameter PARITY_ODD=0/1 inverts it. Frame length grows by 16*DIV clocks.
- When not defined, there is no PARITY state and no PARITY_ODD parameter, and the frame is exactly 8N1.

Decomposition:
- Package uart_pkg: state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4, 3-bit) and the OVERSAMPLE=16 constant.
- Sub-module uart_baud_tick: parameter DIV; ports clk, rst, clr, tick. Instantiated once.
- All other logic lives in a single FSM plus datapath module.

Test Plan:
- Bench uses CLK_FREQ=6_400_000, BAUD=100_000 (DIV=4, 64 clk/bit). Pulse tx_start with din=8'hA5 -> tx low 1 clk later for 64 clk, then bits 1,0,1,0,0,1,0,1 at 64 clk each, then high for 64 clk. tx_done pulses exactly 640 clk after the accept edge. busy is high for 640 clk.
- Pulse tx_start again 100 clk into a frame with din=8'h00 -> ignored; serialized byte is still 8'hA5 and only one tx_done occurs.
- Assert tx_start in the tx_done cycle with din=8'h3C -> second start bit begins the next clk with no idle gap; byte 8'h3C is received.
- Assert rst at clk 300 of a frame -> tx=1 immediately, busy=0, no tx_done. The next tx_start after release sends a full, correct frame.
- STOP_TICKS=32, din=8'hFF -> stop high for 128 clk; tx_done at 704 clk.
- With UART_TX_PARITY_EN, PARITY_ODD=0, din=8'h07 -> parity bit 1 after bit 7; tx_done at 704 clk.
